// File: rtl/fetch_pkg.sv
// Shared widths, FSM state type and the prefetch entry layout for the fetch stage.
package fetch_pkg;

  localparam int XLEN   = 64;
  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] NOP_INST = 32'h00000013;

  typedef enum logic {
    FETCH,
    FAULT
  } fetchState_t;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // A fetch address is unusable if it is not word aligned or lies past the memory.
  function automatic logic badTarget(input logic [XLEN-1:0] addr,
                                     input logic [XLEN-1:0] limit);
    return (addr[1:0] != 2'b00) || (addr >= limit);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch buffer between the PC sequencer and decode; head reads as zero when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_head,
  output logic         o_valid,
  output logic         o_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t   r_mem [DEPTH];
  logic [AW-1:0]  r_rdPtr;
  logic [AW-1:0]  r_wrPtr;
  logic [AW:0]    r_count;

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  // Flush shares the reset path so a redirect empties the buffer in one edge.
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (i_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end

  assign o_valid = (r_count != '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_head  = o_valid ? r_mem[r_rdPtr] : '0;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fills the prefetch FIFO and tracks fetch faults.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              IMEM_WORDS = 128,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [XLEN-1:0]   imem_pc,
  input  logic [INST_W-1:0] imem_instruction,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [XLEN-1:0]   if_pc,
  output logic [INST_W-1:0] if_instruction,
  output logic              fault,
  output logic [XLEN-1:0]   fault_pc
);

  localparam logic [XLEN-1:0] LIMIT = XLEN'(IMEM_WORDS * 4);

  fetchState_t     r_state, w_stateNext;
  logic [XLEN-1:0] r_pc, w_pcNext;
  logic            r_fault, w_faultNext;
  logic [XLEN-1:0] r_faultPc, w_faultPcNext;

  logic            w_push;
  logic            w_pop;
  logic            w_flush;
  logic            w_full;
  fetch_entry_t    w_pushData;
  fetch_entry_t    w_head;

  assign w_pop = if_valid && if_ready;

  always_comb begin
    w_stateNext   = r_state;
    w_pcNext      = r_pc;
    w_faultNext   = r_fault;
    w_faultPcNext = r_faultPc;
    w_push        = 1'b0;
    w_flush       = 1'b0;
    if (redirect_valid) begin
      w_flush = 1'b1;
      if (badTarget(redirect_pc, LIMIT)) begin
        w_stateNext   = FAULT;
        w_faultNext   = 1'b1;
        w_faultPcNext = redirect_pc;
      end else begin
        w_stateNext = FETCH;
        w_pcNext    = redirect_pc;
        w_faultNext = 1'b0;
      end
    end else begin
      case (r_state)
        FETCH: begin
          if (badTarget(r_pc, LIMIT)) begin
            w_stateNext   = FAULT;
            w_faultNext   = 1'b1;
            w_faultPcNext = r_pc;
          end else if (!w_full || w_pop) begin
            w_push   = 1'b1;
            w_pcNext = r_pc + XLEN'(4);
          end
        end
        FAULT: begin
          w_stateNext = FAULT;
        end
        default: begin
          w_stateNext = FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= FETCH;
      r_pc      <= RESET_PC;
      r_fault   <= 1'b0;
      r_faultPc <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_pc      <= w_pcNext;
      r_fault   <= w_faultNext;
      r_faultPc <= w_faultPcNext;
    end
  end

  assign w_pushData.pc   = r_pc;
  assign w_pushData.inst = imem_instruction;

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_flush(w_flush),
    .i_data (w_pushData),
    .o_head (w_head),
    .o_valid(if_valid),
    .o_full (w_full)
  );

  assign imem_pc        = r_pc;
  assign if_pc          = w_head.pc;
  assign if_instruction = w_head.inst;
  assign fault          = r_fault;
  assign fault_pc       = r_faultPc;

endmodule
